hamming74_serial_rx: RTL

- Receive end of the team's Hamming(7,4) link: deserialises a bit-serial stream of 7-bit codewords, computes the syndrome and corrects any single-bit error.
- Presents the corrected nibble on a valid/ready output port.
- Counts corrected codewords in a saturating counter for link-health reporting.
- Sits between the serial link pins (after synchronisation) and the nibble consumer.

---
 rtl/hamming_pkg.sv | 29 ++
 rtl/hamming74_decode.sv | 26 ++
 rtl/hamming74_serial_rx.sv | 105 ++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword geometry, syndrome map and the parity
// function used by both the encoder and this receiver.
package hamming_pkg;

  localparam int N  = 4;
  localparam int M  = 3;
  localparam int CW = N + M;

  typedef logic [CW-1:0] codeword_t;
  typedef logic [N-1:0]  data_t;
  typedef logic [M-1:0]  syndrome_t;

  typedef struct packed {
    data_t     data;
    syndrome_t syndrome;
    logic      corrected;
  } decode_t;

  localparam syndrome_t SYN_D0 = 3'b011;
  localparam syndrome_t SYN_D1 = 3'b101;
  localparam syndrome_t SYN_D2 = 3'b110;
  localparam syndrome_t SYN_D3 = 3'b111;

  // Returns {p2, p1, p0} for a data nibble.
  function automatic syndrome_t calc_parity(input data_t d);
    return {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

endpackage

// File: rtl/hamming74_decode.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
// Double errors alias onto a single-bit syndrome and are miscorrected by design.
module hamming74_decode
  import hamming_pkg::*;
(
  input  logic [CW-1:0] cw,
  output logic [N-1:0]  data,
  output logic [M-1:0]  syndrome,
  output logic          corrected
);

  always_comb begin
    syndrome  = calc_parity(cw[N-1:0]) ^ cw[CW-1:N];
    data      = cw[N-1:0];
    corrected = |syndrome;
    // Syndromes 001/010/100 point at a parity bit, so the data passes through.
    case (syndrome)
      SYN_D0:  data[0] = ~cw[0];
      SYN_D1:  data[1] = ~cw[1];
      SYN_D2:  data[2] = ~cw[2];
      SYN_D3:  data[3] = ~cw[3];
      default: data    = cw[N-1:0];
    endcase
  end

endmodule

// File: rtl/hamming74_serial_rx.sv
// Serial Hamming(7,4) receiver: assembles LSB-first codewords, corrects single-bit
// errors into a one-entry valid/ready output register and counts corrected words.
module hamming74_serial_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             resync,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clear
);

  localparam logic [0:0] COLLECT  = 1'b0;
  localparam logic [0:0] LAST     = 1'b1;
  localparam logic [2:0] LAST_IDX = 3'd6;

  logic [2:0]    bit_cnt;
  logic [CW-2:0] shift_p0;
  logic [0:0]    state;
  logic          xfer;
  logic          load;
  logic          drain;
  codeword_t     word;
  decode_t       dec;
  decode_t       out_p1;
  logic          vld_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign state    = (bit_cnt == LAST_IDX) ? LAST : COLLECT;
  assign in_ready = !(state == LAST && vld_p1 && !out_ready);
  assign xfer     = in_valid && in_ready && !resync;
  assign load     = xfer && (state == LAST);
  assign drain    = vld_p1 && out_ready;

  // The 7th bit completes the word combinationally so decode registers at T+1.
  assign word = {in_bit, shift_p0};

  hamming74_decode u_decode (
    .cw        (word),
    .data      (dec.data),
    .syndrome  (dec.syndrome),
    .corrected (dec.corrected)
  );

  // Stage 0: bit collection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      shift_p0 <= '0;
    end else if (resync) begin
      bit_cnt  <= 3'd0;
      shift_p0 <= '0;
    end else if (xfer) begin
      if (state == LAST) begin
        bit_cnt  <= 3'd0;
        shift_p0 <= '0;
      end else begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_p0 <= {in_bit, shift_p0[CW-2:1]};
      end
    end
  end

  // Stage 1: decoded output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (load) begin
      out_p1 <= dec;
      vld_p1 <= 1'b1;
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if (load && dec.corrected) begin
      err_count <= sat_inc(err_count);
    end
  end

  assign out_data      = out_p1.data;
  assign out_syndrome  = out_p1.syndrome;
  assign out_corrected = out_p1.corrected;
  assign out_valid     = vld_p1;

endmodule
